load_store_controller: RTL and testbench

// Sequences data-memory accesses for LOAD/STORE instructions using the effective address (rs1 + immediate).

---
 rtl/load_store_controller.sv | 187 ++++++++++++++++++
 tb/tb_load_store_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_controller.sv
// Load/store controller: sequences data-memory accesses for RV32I LOAD/STORE,
// aligns store lanes, splits word-crossing accesses and extends load data.
module load_store_controller #(
  parameter int unsigned SUPPORT_MISALIGNED = 1,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_store_data,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_error,
  output logic        stall,
  output logic        mem_request,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_write_data,
  input  logic        mem_ready,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS_0, ACCESS_1, RESPOND} state_t;

  localparam logic [8:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[8:0];

  state_t      r_state;
  logic        r_write;
  logic [2:0]  r_funct3;
  logic [29:0] r_word;
  logic [1:0]  r_offset;
  logic [7:0]  r_mask8;
  logic [63:0] r_wdata64;
  logic        r_cross;
  logic        r_err;
  logic        r_gap;
  logic [7:0]  r_cnt;
  logic [31:0] r_lo;
  logic [31:0] r_hi;

  logic [2:0]  w_size;
  logic [3:0]  w_size_mask;
  logic        w_cross;
  logic        w_illegal;
  logic        w_reject;
  logic [8:0]  w_cnt_next;
  logic        w_timeout;
  logic [31:0] w_raw;
  logic [31:0] w_ext;

  // Decode the incoming request; only consulted on the acceptance cycle
  always_comb begin
    w_size      = 3'd4;
    w_size_mask = 4'b1111;
    case (req_funct3[1:0])
      2'b00:   begin w_size = 3'd1; w_size_mask = 4'b0001; end
      2'b01:   begin w_size = 3'd2; w_size_mask = 4'b0011; end
      default: begin w_size = 3'd4; w_size_mask = 4'b1111; end
    endcase
    w_cross   = ({1'b0, req_address[1:0]} + w_size) > 3'd4;
    w_illegal = req_write ? (req_funct3 >= 3'b011)
                          : ((req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                             (req_funct3 == 3'b111));
    w_reject  = w_illegal || (w_cross && (SUPPORT_MISALIGNED == 0));
  end

  // Wait-cycle counter: abort once the count would reach the limit
  always_comb begin
    w_cnt_next = {1'b0, r_cnt} + 9'd1;
    w_timeout  = (TIMEOUT_CYCLES != 0) && (w_cnt_next >= TIMEOUT_LIMIT);
  end

  // Control FSM with request latch, read capture and timeout counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_write   <= 1'b0;
      r_funct3  <= '0;
      r_word    <= '0;
      r_offset  <= '0;
      r_mask8   <= '0;
      r_wdata64 <= '0;
      r_cross   <= 1'b0;
      r_err     <= 1'b0;
      r_gap     <= 1'b0;
      r_cnt     <= '0;
      r_lo      <= '0;
      r_hi      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_write   <= req_write;
            r_funct3  <= req_funct3;
            r_word    <= req_address[31:2];
            r_offset  <= req_address[1:0];
            r_mask8   <= {4'b0000, w_size_mask} << req_address[1:0];
            r_wdata64 <= {32'b0, req_store_data} << {req_address[1:0], 3'b000};
            r_cross   <= w_cross;
            r_gap     <= 1'b0;
            r_cnt     <= '0;
            r_lo      <= '0;
            r_hi      <= '0;
            r_err     <= w_reject;
            r_state   <= w_reject ? RESPOND : ACCESS_0;
          end
        end
        ACCESS_0: begin
          if (mem_ready) begin
            r_lo  <= mem_read_data;
            r_cnt <= '0;
            if (r_cross) begin
              r_gap   <= 1'b1;
              r_state <= ACCESS_1;
            end else begin
              r_state <= RESPOND;
            end
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= RESPOND;
          end else begin
            r_cnt <= w_cnt_next[7:0];
          end
        end
        ACCESS_1: begin
          // First ACCESS_1 cycle is the idle gap: request low, mem_ready ignored
          if (r_gap) begin
            r_gap <= 1'b0;
          end else if (mem_ready) begin
            r_hi    <= mem_read_data;
            r_state <= RESPOND;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= RESPOND;
          end else begin
            r_cnt <= w_cnt_next[7:0];
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Load-result alignment and sign/zero extension from captured words
  always_comb begin
    w_raw = 32'({r_hi, r_lo} >> {r_offset, 3'b000});
    case (r_funct3)
      3'b000:  w_ext = {{24{w_raw[7]}}, w_raw[7:0]};
      3'b001:  w_ext = {{16{w_raw[15]}}, w_raw[15:0]};
      3'b010:  w_ext = w_raw;
      3'b100:  w_ext = {24'b0, w_raw[7:0]};
      3'b101:  w_ext = {16'b0, w_raw[15:0]};
      default: w_ext = '0;
    endcase
  end

  // Output decode from registered state and latched request
  always_comb begin
    req_ready       = (r_state == IDLE);
    stall           = (r_state != IDLE);
    mem_request     = (r_state == ACCESS_0) || ((r_state == ACCESS_1) && !r_gap);
    mem_write       = mem_request && r_write;
    mem_address     = '0;
    mem_byte_enable = '0;
    mem_write_data  = '0;
    if (r_state == ACCESS_0) begin
      mem_address     = {r_word, 2'b00};
      mem_byte_enable = r_mask8[3:0];
      mem_write_data  = r_wdata64[31:0];
    end else if (mem_request) begin
      mem_address     = {r_word + 30'd1, 2'b00};
      mem_byte_enable = r_mask8[7:4];
      mem_write_data  = r_wdata64[63:32];
    end
    resp_valid = (r_state == RESPOND);
    resp_error = resp_valid && r_err;
    resp_data  = (resp_valid && !r_err && !r_write) ? w_ext : '0;
  end

endmodule

// File: tb/tb_load_store_controller.sv
// Directed self-checking bench for load_store_controller.
module tb_load_store_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_valid_b;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address, req_store_data;
  logic        mem_ready;
  logic [31:0] mem_read_data;

  logic        req_ready, resp_valid, resp_error, stall;
  logic [31:0] resp_data;
  logic        mem_request, mem_write;
  logic [31:0] mem_address, mem_write_data;
  logic [3:0]  mem_byte_enable;

  logic        nb_req_ready, nb_resp_valid, nb_resp_error, nb_stall;
  logic [31:0] nb_resp_data;
  logic        nb_mem_request, nb_mem_write;
  logic [31:0] nb_mem_address, nb_mem_write_data;
  logic [3:0]  nb_mem_byte_enable;

  int checks   = 0;
  int failures = 0;

  // Per-transaction observations
  int          n_acc, lat, gap;
  logic        got_resp, ready_at_req;
  logic [31:0] acc_addr [2];
  logic [3:0]  acc_be   [2];
  logic [31:0] acc_wd   [2];
  logic        acc_wr   [2];
  logic [31:0] obs_data;
  logic        obs_err;
  logic        saw_resp;

  load_store_controller #(.SUPPORT_MISALIGNED(1), .TIMEOUT_CYCLES(4)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_address(req_address), .req_store_data(req_store_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error), .stall(stall),
    .mem_request(mem_request), .mem_write(mem_write), .mem_address(mem_address),
    .mem_byte_enable(mem_byte_enable), .mem_write_data(mem_write_data),
    .mem_ready(mem_ready), .mem_read_data(mem_read_data)
  );

  load_store_controller #(.SUPPORT_MISALIGNED(0), .TIMEOUT_CYCLES(0)) u_dut_na (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_b), .req_ready(nb_req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_address(req_address), .req_store_data(req_store_data),
    .resp_valid(nb_resp_valid), .resp_data(nb_resp_data), .resp_error(nb_resp_error),
    .stall(nb_stall),
    .mem_request(nb_mem_request), .mem_write(nb_mem_write), .mem_address(nb_mem_address),
    .mem_byte_enable(nb_mem_byte_enable), .mem_write_data(nb_mem_write_data),
    .mem_ready(mem_ready), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and act as memory: access k is acknowledged after wk
  // wait cycles with read word rdk. Observations land in module variables.
  task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input int w0, input logic [31:0] rd0,
                         input int w1, input logic [31:0] rd1);
    int   wc;
    logic prev_req;
    n_acc = 0; got_resp = 1'b0; lat = 0; gap = 0; wc = 0; prev_req = 1'b0;
    obs_data = '0; obs_err = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_address = a; req_store_data = sd;
    ready_at_req = req_ready;
    @(negedge clk);
    // Scramble request inputs: an in-flight access must not follow them
    req_valid = 1'b0; req_write = ~wr; req_funct3 = 3'b010;
    req_address = 32'hAAAA_5555; req_store_data = ~sd;
    for (int c = 1; c <= 60 && !got_resp; c++) begin
      mem_ready = 1'b0;
      if (resp_valid) begin
        got_resp = 1'b1; lat = c; obs_data = resp_data; obs_err = resp_error;
      end else if (mem_request) begin
        if (!prev_req && n_acc < 2) begin
          acc_addr[n_acc] = mem_address; acc_be[n_acc] = mem_byte_enable;
          acc_wd[n_acc] = mem_write_data; acc_wr[n_acc] = mem_write;
          n_acc++; wc = 0;
        end
        if (wc == ((n_acc == 1) ? w0 : w1)) begin
          mem_ready = 1'b1; mem_read_data = (n_acc == 1) ? rd0 : rd1;
        end
        wc++;
      end else if (n_acc > 0) begin
        gap++;
        mem_ready = 1'b1; mem_read_data = 32'hBAD0_BAD0;
      end
      prev_req = mem_request;
      if (!got_resp) @(negedge clk);
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_valid_b = 1'b0; req_write = 1'b0;
    req_funct3 = '0; req_address = '0; req_store_data = '0;
    mem_ready = 1'b0; mem_read_data = '0;
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_mem_request", mem_request, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_addr", mem_address, 0);
    @(negedge clk); reset = 1'b1;

    // LW 0x100, two wait cycles
    run_req(1'b0, 3'b010, 32'h0000_0100, 32'h0, 2, 32'hDEAD_BEEF, 0, 32'h0);
    chk("lw_ready", ready_at_req, 1);
    chk("lw_nacc", n_acc, 1);
    chk("lw_addr", acc_addr[0], 32'h0000_0100);
    chk("lw_be", acc_be[0], 4'b1111);
    chk("lw_wr", acc_wr[0], 0);
    chk("lw_data", obs_data, 32'hDEAD_BEEF);
    chk("lw_err", obs_err, 0);
    chk("lw_lat", lat, 4);
    @(negedge clk);
    chk("lw_idle_after", req_ready, 1);

    // LB / LBU 0x103
    run_req(1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 32'h8000_0000, 0, 32'h0);
    chk("lb_be", acc_be[0], 4'b1000);
    chk("lb_addr", acc_addr[0], 32'h0000_0100);
    chk("lb_data", obs_data, 32'hFFFF_FF80);
    chk("lb_lat", lat, 2);
    run_req(1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 32'h8000_0000, 0, 32'h0);
    chk("lbu_data", obs_data, 32'h0000_0080);

    // LH 0x102 (ends exactly at the word boundary, no split)
    run_req(1'b0, 3'b001, 32'h0000_0102, 32'h0, 1, 32'hF00D_1234, 0, 32'h0);
    chk("lh_nacc", n_acc, 1);
    chk("lh_be", acc_be[0], 4'b1100);
    chk("lh_data", obs_data, 32'hFFFF_F00D);

    // SB 0x001
    run_req(1'b1, 3'b000, 32'h0000_0001, 32'h0000_00AB, 0, 32'h0, 0, 32'h0);
    chk("sb_be", acc_be[0], 4'b0010);
    chk("sb_wd", acc_wd[0], 32'h0000_AB00);
    chk("sb_wr", acc_wr[0], 1);
    chk("sb_resp_data", obs_data, 0);

    // SH 0x003 split
    run_req(1'b1, 3'b001, 32'h0000_0003, 32'h0000_1234, 0, 32'h0, 1, 32'h0);
    chk("sh_nacc", n_acc, 2);
    chk("sh_a0", acc_addr[0], 32'h0000_0000);
    chk("sh_be0", acc_be[0], 4'b1000);
    chk("sh_wd0", acc_wd[0], 32'h3400_0000);
    chk("sh_a1", acc_addr[1], 32'h0000_0004);
    chk("sh_be1", acc_be[1], 4'b0001);
    chk("sh_wd1", acc_wd[1], 32'h0000_0012);
    chk("sh_gap", gap, 1);
    chk("sh_err", obs_err, 0);
    chk("sh_resp_data", obs_data, 0);

    // LW 0xFFFFFFFE split with address wrap
    run_req(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 0, 32'h1122_3344, 0, 32'h5566_7788);
    chk("lwx_nacc", n_acc, 2);
    chk("lwx_a0", acc_addr[0], 32'hFFFF_FFFC);
    chk("lwx_be0", acc_be[0], 4'b1100);
    chk("lwx_a1", acc_addr[1], 32'h0000_0000);
    chk("lwx_be1", acc_be[1], 4'b0011);
    chk("lwx_data", obs_data, 32'h7788_1122);
    chk("lwx_lat", lat, 4);

    // Timeout: memory never ready, limit 4
    run_req(1'b0, 3'b010, 32'h0000_0040, 32'h0, 1000, 32'h0, 0, 32'h0);
    chk("to_got_resp", got_resp, 1);
    chk("to_err", obs_err, 1);
    chk("to_data", obs_data, 0);
    chk("to_lat", lat, 5);
    chk("to_nacc", n_acc, 1);
    @(negedge clk);
    chk("to_idle", req_ready, 1);
    chk("to_req_low", mem_request, 0);

    // Illegal load funct3
    run_req(1'b0, 3'b011, 32'h0000_0010, 32'h0, 0, 32'h0, 0, 32'h0);
    chk("ill_err", obs_err, 1);
    chk("ill_nacc", n_acc, 0);
    chk("ill_lat", lat, 1);
    // Illegal store funct3
    run_req(1'b1, 3'b011, 32'h0000_0010, 32'h1, 0, 32'h0, 0, 32'h0);
    chk("ill_st_err", obs_err, 1);
    chk("ill_st_nacc", n_acc, 0);

    // Misaligned rejection on the instance without split support
    @(negedge clk);
    req_valid_b = 1'b1; req_write = 1'b0; req_funct3 = 3'b001; req_address = 32'h0000_0003;
    @(negedge clk);
    req_valid_b = 1'b0;
    chk("na_resp_valid", nb_resp_valid, 1);
    chk("na_err", nb_resp_error, 1);
    chk("na_mem_request", nb_mem_request, 0);
    chk("na_data", nb_resp_data, 0);
    @(negedge clk);
    chk("na_idle", nb_req_ready, 1);

    // Reset during ACCESS_1
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_address = 32'hFFFF_FFFE;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rs_acc0_req", mem_request, 1);
    mem_ready = 1'b1; mem_read_data = 32'h1111_1111;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rs_acc1_req", mem_request, 1);
    reset = 1'b0;
    #1;
    chk("rs_req_drop", mem_request, 0);
    chk("rs_ready", req_ready, 1);
    chk("rs_stall", stall, 0);
    saw_resp = resp_valid;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      saw_resp = saw_resp | resp_valid;
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      saw_resp = saw_resp | resp_valid;
    end
    chk("rs_no_resp", saw_resp, 0);

    // Next LW after reset
    run_req(1'b0, 3'b010, 32'h0000_0200, 32'h0, 0, 32'h0BAD_F00D, 0, 32'h0);
    chk("post_addr", acc_addr[0], 32'h0000_0200);
    chk("post_data", obs_data, 32'h0BAD_F00D);
    chk("post_err", obs_err, 0);
    chk("post_lat", lat, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
